// File: rtl/cfg_fabric_n_if.sv
// Configuration-port and datapath signal bundle for cfg_fabric_n.
// The slave modport is the fabric's view; the master modport is the driver's view.
interface cfg_fabric_n_if #(
   parameter int NUM_CLB = 4,
   parameter int CLB_W   = 2
);
   localparam int W = NUM_CLB * CLB_W;

   logic         cfg_start;
   logic         cfg_valid;
   logic         cfg_bit;
   logic         cfg_ready;
   logic         cfg_done;
   logic         in_valid;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         c_external;
   logic         out_valid;
   logic [W-1:0] sum_final;
   logic         cout_final;

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, in_valid, op_a, op_b, c_external,
      output cfg_ready, cfg_done, out_valid, sum_final, cout_final
   );

   modport master (
      output cfg_start, cfg_valid, cfg_bit, in_valid, op_a, op_b, c_external,
      input  cfg_ready, cfg_done, out_valid, sum_final, cout_final
   );
endinterface

// File: rtl/cfg_fabric_n.sv
// Configurable chain of add/subtract blocks with a serial, atomically committed
// configuration frame and a one-cycle registered datapath.
module cfg_fabric_n #(
   parameter int NUM_CLB = 4,
   parameter int CLB_W   = 2
) (
   input  logic          CLK,
   input  logic          RST,
   cfg_fabric_n_if.slave bus
);
   localparam int W  = NUM_CLB * CLB_W;
   localparam int FL = 3 * NUM_CLB;
   localparam int CW = $clog2(FL + 1);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

   // Block 0 takes c_external, every other block chains from its neighbour.
   function automatic logic [FL-1:0] default_cfg();
      logic [FL-1:0] f;
      f = {FL{1'b0}};
      for (int i = 1; i < NUM_CLB; i++) begin
         f[3*i +: 3] = 3'b001;
      end
      return f;
   endfunction

   localparam logic [FL-1:0] DEF_CFG = default_cfg();

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [FL-1:0]  shadow_q;
   logic [FL-1:0]  active_q;
   logic           done_q;

   logic           vld_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           cext_q;
   logic [FL-1:0]  snap_q;

   logic [W-1:0]   sum_d;
   logic           cout_d;
   logic [W-1:0]   sum_q;
   logic           cout_q;
   logic           ovld_q;

   // Configuration loader: shadow frame fills LSB first, then commits in one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_ZERO;
         shadow_q <= {FL{1'b0}};
         active_q <= DEF_CFG;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.cfg_start) begin
                  state_q  <= SHIFT;
                  cnt_q    <= CNT_ZERO;
                  shadow_q <= {FL{1'b0}};
               end
            end
            SHIFT: begin
               if (bus.cfg_start) begin
                  cnt_q    <= CNT_ZERO;
                  shadow_q <= {FL{1'b0}};
               end else if (bus.cfg_valid) begin
                  shadow_q <= {bus.cfg_bit, shadow_q[FL-1:1]};
                  cnt_q    <= cnt_q + CNT_ONE;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= COMMIT;
                     done_q  <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               active_q <= shadow_q;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Operand stage snapshots the active config so a commit cannot disturb this operation.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_q  <= 1'b0;
         a_q    <= {W{1'b0}};
         b_q    <= {W{1'b0}};
         cext_q <= 1'b0;
         snap_q <= DEF_CFG;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
            cext_q <= bus.c_external;
            snap_q <= active_q;
         end
      end
   end

   // Ripple chain through all blocks, each with its own carry-in select and mode.
   always_comb begin
      logic             carry;
      logic             cin;
      logic [CLB_W-1:0] bx;
      logic [CLB_W:0]   t;
      sum_d = {W{1'b0}};
      carry = cext_q;
      cin   = 1'b0;
      bx    = {CLB_W{1'b0}};
      t     = {(CLB_W+1){1'b0}};
      for (int i = 0; i < NUM_CLB; i++) begin
         case (snap_q[3*i +: 2])
            2'b00:   cin = cext_q;
            2'b01:   cin = carry;
            2'b10:   cin = 1'b0;
            2'b11:   cin = 1'b1;
            default: cin = cext_q;
         endcase
         if (snap_q[3*i + 2]) begin
            bx = ~b_q[i*CLB_W +: CLB_W];
         end else begin
            bx = b_q[i*CLB_W +: CLB_W];
         end
         t = {1'b0, a_q[i*CLB_W +: CLB_W]} + {1'b0, bx} + {{CLB_W{1'b0}}, cin};
         sum_d[i*CLB_W +: CLB_W] = t[CLB_W-1:0];
         carry = t[CLB_W];
      end
      cout_d = carry;
   end

   // Result stage; sum and carry hold between valid operations.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ovld_q <= 1'b0;
         sum_q  <= {W{1'b0}};
         cout_q <= 1'b0;
      end else begin
         ovld_q <= vld_q;
         if (vld_q) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
         end
      end
   end

   assign bus.cfg_ready  = (state_q == SHIFT);
   assign bus.cfg_done   = done_q;
   assign bus.out_valid  = ovld_q;
   assign bus.sum_final  = sum_q;
   assign bus.cout_final = cout_q;
endmodule

// File: tb/tb_cfg_fabric_n.sv
// Self-checking bench for cfg_fabric_n: directed vector table, hand-written
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_cfg_fabric_n;
   localparam int NUM_CLB = 4;
   localparam int CLB_W   = 2;
   localparam int W       = NUM_CLB * CLB_W;
   localparam int FL      = 3 * NUM_CLB;
   localparam logic [FL-1:0] DEF_FRAME = 12'h248;

   logic CLK = 1'b0;
   logic RST;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   logic [FL-1:0] cur_cfg;

   cfg_fabric_n_if #(.NUM_CLB(NUM_CLB), .CLB_W(CLB_W)) bus ();

   cfg_fabric_n #(.NUM_CLB(NUM_CLB), .CLB_W(CLB_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.cfg_done === 1'b1) done_cnt++;
   end

   typedef struct {
      logic [FL-1:0] frame;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          cext;
      logic [W-1:0]  sum;
      logic          cout;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: apply the per-block rules with integer arithmetic.
   function automatic logic [W:0] model(input logic [FL-1:0] cfg, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cext);
      int m;
      int prev;
      int res;
      int pw;
      logic [W:0] r;
      m = 1 << CLB_W;
      prev = int'(cext);
      res = 0;
      pw = 1;
      for (int i = 0; i < NUM_CLB; i++) begin
         int f;
         int ai;
         int bi;
         int cin;
         int t;
         f  = int'((cfg >> (3 * i)) & 12'd7);
         ai = int'(a >> (CLB_W * i)) % m;
         bi = int'(b >> (CLB_W * i)) % m;
         if (f / 4 == 1) bi = m - 1 - bi;
         case (f % 4)
            0:       cin = int'(cext);
            1:       cin = prev;
            2:       cin = 0;
            default: cin = 1;
         endcase
         t = ai + bi + cin;
         res = res + (t % m) * pw;
         prev = t / m;
         pw = pw * m;
      end
      r[W-1:0] = res[W-1:0];
      r[W] = prev[0];
      return r;
   endfunction

   task automatic idle_inputs();
      bus.cfg_start  = 1'b0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_bit    = 1'b0;
      bus.in_valid   = 1'b0;
      bus.op_a       = 8'h00;
      bus.op_b       = 8'h00;
      bus.c_external = 1'b0;
   endtask

   task automatic start_load();
      @(negedge CLK);
      bus.cfg_start = 1'b1;
   endtask

   task automatic send_bits(input logic [FL-1:0] frame, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (i == 0) chk("ready_in_shift", 32'(bus.cfg_ready), 32'd1);
         bus.cfg_start = 1'b0;
         bus.cfg_valid = 1'b1;
         bus.cfg_bit   = frame[i];
      end
   endtask

   task automatic finish_load(input int d0, input logic [FL-1:0] frame);
      @(negedge CLK);
      bus.cfg_valid = 1'b0;
      bus.cfg_bit   = 1'b0;
      chk("done_on_commit", 32'(bus.cfg_done), 32'd1);
      @(negedge CLK);
      chk("ready_after_commit", 32'(bus.cfg_ready), 32'd0);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      cur_cfg = frame;
   endtask

   task automatic load_frame(input logic [FL-1:0] frame);
      int d0;
      d0 = done_cnt;
      start_load();
      send_bits(frame, FL);
      finish_load(d0, frame);
   endtask

   task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cext, input logic [W-1:0] es, input logic ec);
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.op_a = a;
      bus.op_b = b;
      bus.c_external = cext;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      chk({name, "_ov_early"}, 32'(bus.out_valid), 32'd0);
      @(negedge CLK);
      chk({name, "_ov"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_sum"}, 32'(bus.sum_final), 32'(es));
      chk({name, "_cout"}, 32'(bus.cout_final), 32'(ec));
      @(negedge CLK);
      chk({name, "_ov_pulse"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic rand_stream(input int n);
      logic       pv[2];
      logic [W:0] pe[2];
      logic       iv;
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      pe[0] = '0;
      pe[1] = '0;
      for (int t = 0; t < n + 2; t++) begin
         @(negedge CLK);
         chk("rand_ov", 32'(bus.out_valid), 32'(pv[1]));
         if (pv[1]) chk("rand_res", 32'({bus.cout_final, bus.sum_final}), 32'(pe[1]));
         pv[1] = pv[0];
         pe[1] = pe[0];
         iv = (t < n) && ($urandom_range(0, 3) != 0);
         bus.in_valid   = iv;
         bus.op_a       = W'($urandom);
         bus.op_b       = W'($urandom);
         bus.c_external = 1'($urandom);
         pv[0] = iv;
         pe[0] = model(cur_cfg, bus.op_a, bus.op_b, bus.c_external);
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int d0;
      vecs[0]  = '{12'h248, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1]  = '{12'h248, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[2]  = '{12'h248, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[3]  = '{12'h248, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[4]  = '{12'hB6F, 8'h50, 8'h20, 1'b0, 8'h30, 1'b1};
      vecs[5]  = '{12'hB6F, 8'h20, 8'h50, 1'b0, 8'hD0, 1'b0};
      vecs[6]  = '{12'hB6F, 8'h50, 8'h20, 1'b1, 8'h30, 1'b1};
      vecs[7]  = '{12'h288, 8'h0F, 8'h01, 1'b0, 8'h00, 1'b0};
      vecs[8]  = '{12'h6DB, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0};
      vecs[9]  = '{12'h000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[10] = '{12'h000, 8'h00, 8'h00, 1'b1, 8'h55, 1'b0};

      idle_inputs();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
      chk("rst_done", 32'(bus.cfg_done), 32'd0);
      chk("rst_ov", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum_final), 32'd0);
      chk("rst_cout", 32'(bus.cout_final), 32'd0);
      RST = 1'b0;
      cur_cfg = DEF_FRAME;

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].frame != cur_cfg) load_frame(vecs[i].frame);
         check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cext,
                  vecs[i].sum, vecs[i].cout);
      end

      // Restart: stray bits, then a restart pulse carrying an ignored valid bit.
      d0 = done_cnt;
      start_load();
      send_bits(12'hFFF, 5);
      @(negedge CLK);
      bus.cfg_start = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'b1;
      send_bits(12'hB6F, FL);
      finish_load(d0, 12'hB6F);
      check_op("restart", 8'h50, 8'h20, 1'b0, 8'h30, 1'b1);

      // Reset in the middle of a load.
      d0 = done_cnt;
      start_load();
      send_bits(12'h288, 7);
      @(negedge CLK);
      bus.cfg_valid = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst_ready", 32'(bus.cfg_ready), 32'd0);
      chk("midrst_ov", 32'(bus.out_valid), 32'd0);
      chk("midrst_sum", 32'(bus.sum_final), 32'd0);
      RST = 1'b0;
      repeat (FL + 2) @(negedge CLK);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      cur_cfg = DEF_FRAME;
      check_op("midrst_default", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

      // Operation on the commit cycle uses the old config, the next one the new.
      d0 = done_cnt;
      start_load();
      send_bits(12'h288, FL);
      @(negedge CLK);
      bus.cfg_valid = 1'b0;
      chk("race_done", 32'(bus.cfg_done), 32'd1);
      bus.in_valid = 1'b1;
      bus.op_a = 8'h0F;
      bus.op_b = 8'h01;
      bus.c_external = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      chk("race_old_ov", 32'(bus.out_valid), 32'd1);
      chk("race_old_sum", 32'(bus.sum_final), 32'h10);
      @(negedge CLK);
      chk("race_new_ov", 32'(bus.out_valid), 32'd1);
      chk("race_new_sum", 32'(bus.sum_final), 32'h00);
      @(negedge CLK);
      chk("race_idle_ov", 32'(bus.out_valid), 32'd0);
      chk("race_hold_sum", 32'(bus.sum_final), 32'h00);
      chk("race_done_count", 32'(done_cnt - d0), 32'd1);
      cur_cfg = 12'h288;

      rand_stream(16);
      for (int r = 0; r < 14; r++) begin
         load_frame(FL'($urandom));
         rand_stream(12);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cfg_fabric_n.md
# cfg_fabric_n

Parametrised configurable adder fabric: a chain of `NUM_CLB` logic blocks, each `CLB_W` bits wide. The blocks are joined by per-block carry-in select muxes and a per-block add/subtract mode. Configuration is loaded through a serial bitstream port and committed atomically. Operands are registered and results are produced with fixed one-cycle latency. It generalises the 4×2-bit `config_fpga` fabric to arbitrary width and block count, and adds runtime reconfiguration, subtract mode and a valid handshake.

## Interface
- `NUM_CLB`, 4, number of logic blocks (≥1)
- `CLB_W`, 2, bits per block (≥1)
- `CLK` in 1: single clock, rising edge
- `RST` in 1: reset, asynchronous, active-high
- `cfg_start` in 1: pulse; begins (or restarts) a bitstream load
- `cfg_valid` in 1: `cfg_bit` is valid this cycle
- `cfg_bit` in 1: serial configuration bit
- `cfg_ready` out 1: load in progress, bits accepted
- `cfg_done` out 1: one-cycle pulse when a frame commits
- `in_valid` in 1: operands valid this cycle
- `op_a`, `op_b` in `NUM_CLB*CLB_W`: operands; block i uses bits [i*CLB_W +: CLB_W]
- `c_external` in 1: external carry source
- `out_valid` out 1: `sum_final`/`cout_final` valid
- `sum_final` out `NUM_CLB*CLB_W`: registered result
- `cout_final` out 1: registered carry-out of block `NUM_CLB-1`

## Operation
- **Per-block config field** is 3 bits `{mode, sel[1:0]}`. Field for block i sits at frame bits [3i+2:3i]. Frame length `FL = 3*NUM_CLB`.
- **`sel` (carry-in source):**
  - 00 = `c_external`
  - 01 = carry-out of block i-1 (block 0: `c_external`)
  - 10 = constant 0
  - 11 = constant 1
- **`mode`:** 0 = A+B+cin; 1 = A+~B+cin. ~B is the `CLB_W`-bit inverse. Two's-complement subtract requires `sel` = 11 on the lowest block of the chain.
- **Block result:** `CLB_W`-bit sum; carry-out = bit `CLB_W` of the (`CLB_W`+1)-bit sum. Carry-outs not selected by the next block are dropped.
- **Active config after reset:** block 0 = 000, all others = 001. The fabric then behaves as one full `NUM_CLB*CLB_W`-bit adder with carry-in `c_external`.
- **Config FSM states:** `IDLE`, `SHIFT`, `COMMIT`.
  - `IDLE` → `SHIFT` on `cfg_start`: bit counter and shadow frame cleared.
  - `SHIFT`: each cycle with `cfg_valid` shifts `cfg_bit` into the shadow frame, LSB first (first bit lands in frame bit 0), and increments the counter.
  - `SHIFT`: after the FL-th accepted bit → `COMMIT`.
  - `SHIFT`: `cfg_start` restarts the load, discarding the partial frame and clearing the counter. `cfg_valid` in the same cycle is ignored.
  - `COMMIT` (one cycle): shadow frame is copied to the active config; `cfg_done` = 1; → `IDLE`.
- `cfg_valid` outside `SHIFT` is ignored. `cfg_start` during `COMMIT` is ignored.
- Counter width is `$clog2(FL+1)`.

## Timing
- **Reset values:** `cfg_ready`=0, `cfg_done`=0, `out_valid`=0, `sum_final`=0, `cout_final`=0, FSM=`IDLE`, shadow frame = 0, active config = default.
- **Reset mid-load:** the partial frame is discarded and the active config returns to default.
- `cfg_ready` is a combinational decode of state == `SHIFT`.
- Minimum load time is FL+2 cycles from `cfg_start` to the `cfg_done` pulse.
- **Datapath:** when `in_valid` is sampled at edge k, `sum_final`/`cout_final` update and `out_valid`=1 after edge k+1, i.e. latency 1.
  - `out_valid` is 0 on cycles without a preceding `in_valid`.
  - `sum_final` holds its last value.
- The ripple chain is combinational between the operand register and the output register.
- **Simultaneous events:** an operation sampled on the `COMMIT` cycle uses the old config. The new config applies to operands sampled on the following cycle onward.
- Config changes never corrupt an in-flight result.

## Test plan
All cases use the defaults (8-bit fabric, FL=12).
- **Default adder:** after reset, `op_a`=8'h5A, `op_b`=8'h3C, `c_external`=0, `in_valid` pulse → next cycle `sum_final`=8'h96, `cout_final`=0, `out_valid`=1 for one cycle.
- **Subtract:** load frame 12'hB6F (block 0 = 111, others = 101); `cfg_done` pulses exactly once. Then `op_a`=8'h50, `op_b`=8'h20 → `sum_final`=8'h30, `cout_final`=1.
- **Split chain:** load frame 12'h288 (block 2 `sel`=10). Then `op_a`=8'h0F, `op_b`=8'h01, `c_external`=0 → `sum_final`=8'h00, `cout_final`=0. The same operands under the default config give 8'h10.
- **Restart:** `cfg_start`, 5 bits, `cfg_start`, then the full frame 12'hB6F → a single `cfg_done`; the subtract test passes. The 5 stray bits have no effect.
- **Reset mid-load:** `RST` asserted after 7 bits of 12'h288 → `cfg_ready`=0, no `cfg_done`; the default-adder test then gives 8'h96.
- **Commit race:** `in_valid` with 8'h0F+8'h01 on the `COMMIT` cycle of 12'h288 → result 8'h10 (old config). The same operands one cycle later → 8'h00.
